// File: rtl/psk_qam_mapper.sv
// Serial-bit to Gray-coded BPSK/QPSK/16-QAM symbol mapper.
// Packs 1, 2 or 4 bits per symbol according to a run-time mode; the mode is latched on each symbol's first bit.
module psk_qam_mapper #(
  parameter int W   = 11,
  parameter int AMP = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          mode_i,
  input  logic                valid_i,
  input  logic                data_i,
  input  logic                flush_i,
  output logic                valid_x,
  output logic signed [W-1:0] xr,
  output logic signed [W-1:0] xi,
  output logic                busy_o
);

  localparam int unsigned CW = 3;
  localparam logic signed [W-1:0] L_P1 = W'(AMP);
  localparam logic signed [W-1:0] L_P3 = W'(3 * AMP);
  localparam logic signed [W-1:0] L_M1 = W'(-AMP);
  localparam logic signed [W-1:0] L_M3 = W'(-3 * AMP);

  if (3 * AMP > (2 ** (W - 1)) - 1) begin : g_amp_chk
    $error("psk_qam_mapper: 3*AMP does not fit in signed W bits");
  end

  // Gray-coded 4-level axis value: 00 -3A, 01 -A, 11 +A, 10 +3A
  function automatic logic signed [W-1:0] qam_lvl(input logic [1:0] b);
    case (b)
      2'b00:   qam_lvl = L_M3;
      2'b01:   qam_lvl = L_M1;
      2'b11:   qam_lvl = L_P1;
      default: qam_lvl = L_P3;
    endcase
  endfunction

  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_sr;
  logic [1:0]          r_mode;
  logic                r_valid;
  logic                r_busy;
  logic signed [W-1:0] r_xr;
  logic signed [W-1:0] r_xi;

  logic                w_first;
  logic [1:0]          w_mode;
  logic [CW-1:0]       w_nbits;
  logic [CW-1:0]       w_cnt_inc;
  logic [3:0]          w_sr;
  logic                w_done;
  logic signed [W-1:0] w_xr;
  logic signed [W-1:0] w_xi;

  // The first bit of a symbol uses mode_i directly so BPSK needs no extra cycle
  always_comb begin
    w_first   = (r_cnt == '0);
    w_mode    = w_first ? mode_i : r_mode;
    w_sr      = {r_sr[2:0], data_i};
    w_cnt_inc = r_cnt + CW'(1);
    case (w_mode)
      2'b01:   w_nbits = CW'(2);
      2'b10:   w_nbits = CW'(4);
      default: w_nbits = CW'(1);
    endcase
    w_done = valid_i && !flush_i && (w_cnt_inc == w_nbits);
  end

  // Map the completed group; b0 is the oldest bit in the shift register
  always_comb begin
    w_xr = data_i ? L_P1 : L_M1;
    w_xi = '0;
    case (w_mode)
      2'b01: begin
        w_xr = w_sr[1] ? L_P1 : L_M1;
        w_xi = w_sr[0] ? L_P1 : L_M1;
      end
      2'b10: begin
        w_xr = qam_lvl(w_sr[3:2]);
        w_xi = qam_lvl(w_sr[1:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_sr    <= '0;
      r_mode  <= 2'b00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_xr    <= '0;
      r_xi    <= '0;
    end else begin
      r_valid <= w_done;
      if (flush_i) begin
        r_cnt  <= '0;
        r_sr   <= '0;
        r_busy <= 1'b0;
      end else if (valid_i) begin
        r_sr <= w_sr;
        if (w_first) begin
          r_mode <= mode_i;
        end
        if (w_done) begin
          r_cnt  <= '0;
          r_busy <= 1'b0;
          r_xr   <= w_xr;
          r_xi   <= w_xi;
        end else begin
          r_cnt  <= w_cnt_inc;
          r_busy <= 1'b1;
        end
      end
    end
  end

  assign valid_x = r_valid;
  assign xr      = r_xr;
  assign xi      = r_xi;
  assign busy_o  = r_busy;

endmodule

// File: tb/tb_psk_qam_mapper.sv
// Directed self-checking bench for psk_qam_mapper with A=8 and W=11.
module tb_psk_qam_mapper;

  localparam int W = 11;

  logic                CLK;
  logic                RST;
  logic [1:0]          mode_i;
  logic                valid_i;
  logic                data_i;
  logic                flush_i;
  logic                valid_x;
  logic signed [W-1:0] xr;
  logic signed [W-1:0] xi;
  logic                busy_o;

  int n_vec;
  int n_err;

  psk_qam_mapper #(.W(W), .AMP(8)) u_dut (
    .CLK    (CLK),
    .RST    (RST),
    .mode_i (mode_i),
    .valid_i(valid_i),
    .data_i (data_i),
    .flush_i(flush_i),
    .valid_x(valid_x),
    .xr     (xr),
    .xi     (xi),
    .busy_o (busy_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the capturing edge
  task automatic step(input logic v, input logic d, input logic f, input logic [1:0] m);
    @(negedge CLK);
    valid_i = v;
    data_i  = d;
    flush_i = f;
    mode_i  = m;
    @(posedge CLK);
    #1;
  endtask

  task automatic sym(input string tag, input int exp_r, input int exp_i);
    chk({tag, ".valid"}, int'(valid_x), 1);
    chk({tag, ".xr"}, int'(xr), exp_r);
    chk({tag, ".xi"}, int'(xi), exp_i);
    chk({tag, ".busy"}, int'(busy_o), 0);
  endtask

  function automatic int gray_lvl(input logic [1:0] b);
    case (b)
      2'b00:   return -24;
      2'b01:   return -8;
      2'b11:   return 8;
      default: return 24;
    endcase
  endfunction

  initial begin
    logic [3:0] pat;
    n_vec   = 0;
    n_err   = 0;
    RST     = 1'b1;
    mode_i  = 2'b00;
    valid_i = 1'b0;
    data_i  = 1'b0;
    flush_i = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst.valid", int'(valid_x), 0);
    chk("rst.xr", int'(xr), 0);
    chk("rst.xi", int'(xi), 0);
    chk("rst.busy", int'(busy_o), 0);
    @(negedge CLK);
    RST = 1'b0;

    // BPSK back-to-back
    step(1, 1, 0, 2'b00); sym("bpsk0", 8, 0);
    step(1, 0, 0, 2'b00); sym("bpsk1", -8, 0);
    step(1, 1, 0, 2'b00); sym("bpsk2", 8, 0);
    step(0, 0, 0, 2'b00);
    chk("hold.valid", int'(valid_x), 0);
    chk("hold.xr", int'(xr), 8);

    // QPSK
    step(1, 1, 0, 2'b01);
    chk("qpsk0.busy", int'(busy_o), 1);
    chk("qpsk0.valid", int'(valid_x), 0);
    step(1, 0, 0, 2'b01); sym("qpsk0", 8, -8);
    step(1, 0, 0, 2'b01);
    chk("qpsk1.busy", int'(busy_o), 1);
    step(1, 1, 0, 2'b01); sym("qpsk1", -8, 8);

    // 16-QAM sweep, b0 sent first
    for (int p = 0; p < 16; p++) begin
      pat = 4'(p);
      for (int k = 3; k >= 1; k--) begin
        step(1, pat[k], 0, 2'b10);
        chk($sformatf("qam%0d.midvalid", p), int'(valid_x), 0);
      end
      step(1, pat[0], 0, 2'b10);
      sym($sformatf("qam%0d", p), gray_lvl(pat[3:2]), gray_lvl(pat[1:0]));
    end

    // Gaps and mid-symbol mode change: 1011 as 16-QAM, then BPSK bit 0
    step(1, 1, 0, 2'b10);
    step(0, 0, 0, 2'b10);
    step(1, 0, 0, 2'b10);
    step(0, 0, 0, 2'b00);
    step(0, 0, 0, 2'b00);
    chk("gap.busy", int'(busy_o), 1);
    step(1, 1, 0, 2'b00);
    chk("gap.valid3", int'(valid_x), 0);
    step(0, 0, 0, 2'b00);
    step(1, 1, 0, 2'b00); sym("gap.qam", 24, 8);
    step(1, 0, 0, 2'b00); sym("gap.bpsk", -8, 0);

    // Flush wins over a simultaneous valid bit
    step(1, 1, 0, 2'b01);
    chk("flush.busy_pre", int'(busy_o), 1);
    step(1, 0, 1, 2'b01);
    chk("flush.busy", int'(busy_o), 0);
    chk("flush.valid", int'(valid_x), 0);
    step(1, 0, 0, 2'b01);
    chk("flush.valid1", int'(valid_x), 0);
    step(1, 0, 0, 2'b01); sym("flush.sym", -8, -8);
    step(0, 0, 1, 2'b01);
    chk("flush.idle_busy", int'(busy_o), 0);
    chk("flush.idle_xr", int'(xr), -8);

    // Reserved mode behaves as BPSK
    step(1, 1, 0, 2'b11); sym("rsv0", 8, 0);
    step(1, 0, 0, 2'b11); sym("rsv1", -8, 0);

    // Async reset between edges, mid 16-QAM symbol
    step(1, 1, 0, 2'b10);
    step(1, 1, 0, 2'b10);
    step(1, 1, 0, 2'b10);
    chk("arst.busy_pre", int'(busy_o), 1);
    valid_i = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("arst.valid", int'(valid_x), 0);
    chk("arst.xr", int'(xr), 0);
    chk("arst.xi", int'(xi), 0);
    chk("arst.busy", int'(busy_o), 0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    step(1, 0, 0, 2'b10);
    chk("arst.b0_valid", int'(valid_x), 0);
    step(1, 1, 0, 2'b10);
    step(1, 1, 0, 2'b10);
    step(1, 0, 0, 2'b10); sym("arst.qam", -8, 24);
    step(0, 0, 0, 2'b00);
    chk("arst.strobe_end", int'(valid_x), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
